// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: default word and register-select types plus
// the architectural zero register.
package cpu_types_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_SEL_W  = $clog2(DEF_NREGS);

    typedef logic [DEF_DATA_W-1:0] word_t;
    typedef logic [DEF_SEL_W-1:0]  regsel_t;

    // Hard-wired zero register; writes and claims to it are discarded.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port write-forwarding selector: reports whether any enabled write
// port targets the read address and, if so, the highest-index port's data.
module regfile_fwd_mux
    import cpu_types_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int NWR    = 2
) (
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*SEL_W-1:0]  wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic [SEL_W-1:0]      rsel,
    output logic                  hit,
    output logic [DATA_W-1:0]     fwd_data
);

    always_comb begin
        // NOTE: blocking assignments in combinational logic; the last match in
        // the ascending loop wins, which gives the higher port index priority.
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && (wsel[k*SEL_W +: SEL_W] == rsel) && (rsel != SEL_W'(ZERO_REG))) begin
                hit      = 1'b1;
                fwd_data = wdat[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file with same-cycle write forwarding and
// a per-register pending (scoreboard) bit for RAW hazard detection in decode.
module multiport_register_file
    import cpu_types_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    localparam int SEL_W  = $clog2(NREGS)
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*SEL_W-1:0]  wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic [NRD*SEL_W-1:0]  rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic                  claim_en,
    input  logic [SEL_W-1:0]      claim_sel,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy_vec
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  wr_hit;

    always_comb begin
        regs_d = regs_q;
        wr_hit = '0;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && (wsel[k*SEL_W +: SEL_W] != SEL_W'(ZERO_REG))) begin
                regs_d[wsel[k*SEL_W +: SEL_W]] = wdat[k*DATA_W +: DATA_W];
                wr_hit[wsel[k*SEL_W +: SEL_W]] = 1'b1;
            end
        end
    end

    // Flush beats claim, and a claim beats a write: the claim is the newer producer.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (claim_en && (claim_sel == SEL_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    // NOTE: the storage array is reset because reads must return 0 during and
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic              fwd_hit;
        logic [DATA_W-1:0] fwd_data;
        logic [SEL_W-1:0]  sel;

        assign sel = rsel[j*SEL_W +: SEL_W];

        regfile_fwd_mux #(
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W),
            .NWR    (NWR)
        ) u_fwd (
            .wen      (wen),
            .wsel     (wsel),
            .wdat     (wdat),
            .rsel     (sel),
            .hit      (fwd_hit),
            .fwd_data (fwd_data)
        );

        assign rdat[j*DATA_W +: DATA_W] = fwd_hit ? fwd_data : regs_q[sel];
        assign rbusy[j]                 = busy_q[sel] & ~fwd_hit;
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file at default sizes.
module tb_multiport_register_file;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int SW = 5;

    logic          CLK;
    logic          nRST;
    logic [1:0]    wen;
    logic [2*SW-1:0] wsel;
    logic [2*DW-1:0] wdat;
    logic [2*SW-1:0] rsel;
    logic [2*DW-1:0] rdat;
    logic [1:0]    rbusy;
    logic          claim_en;
    logic [SW-1:0] claim_sel;
    logic          flush;
    logic [NR-1:0] busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    multiport_register_file dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .wen       (wen),
        .wsel      (wsel),
        .wdat      (wdat),
        .rsel      (rsel),
        .rdat      (rdat),
        .rbusy     (rbusy),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge, then settle 1ns so inputs change away from the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        wen = '0; wsel = '0; wdat = '0;
        claim_en = 1'b0; claim_sel = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int p, input logic [SW-1:0] sel, input logic [DW-1:0] dat);
        wen[p] = 1'b1;
        wsel[p*SW +: SW] = sel;
        wdat[p*DW +: DW] = dat;
    endtask

    task automatic set_rd(input logic [SW-1:0] s0, input logic [SW-1:0] s1);
        rsel = {s1, s0};
    endtask

    task automatic chk32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; idle(); set_rd(5'd5, 5'd31);
        #3;
        n_cmp++;
        if (rdat !== '0) begin n_err++; $display("FAIL reset_rdat: got 0x%016h expected 0", rdat); end
        n_cmp++;
        if (busy_vec !== '0) begin n_err++; $display("FAIL reset_busy_vec: got 0x%08h expected 0", busy_vec); end
        n_cmp++;
        if (rbusy !== 2'b00) begin n_err++; $display("FAIL reset_rbusy: got %b expected 00", rbusy); end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_basic_write();
        idle(); set_wr(0, 5'd5, 32'hDEADBEEF); set_rd(5'd0, 5'd1);
        tick();
        idle(); set_rd(5'd5, 5'd0);
        #1;
        chk32("basic_read_reg5", rdat[31:0], 32'hDEADBEEF);
        set_wr(0, 5'd0, 32'h1234); set_rd(5'd0, 5'd0);
        #1;
        chk32("reg0_no_bypass", rdat[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk32("reg0_after_write_p0", rdat[31:0], 32'h0);
        chk32("reg0_after_write_p1", rdat[63:32], 32'h0);
    endtask

    task automatic test_bypass();
        idle(); set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22); set_rd(5'd7, 5'd7);
        #1;
        chk32("bypass_prio_rd1", rdat[63:32], 32'h22);
        chk32("bypass_prio_rd0", rdat[31:0], 32'h22);
        tick();
        idle();
        #1;
        chk32("prio_stored_reg7", rdat[63:32], 32'h22);
        set_wr(0, 5'd8, 32'h33); set_rd(5'd8, 5'd7);
        #1;
        chk32("bypass_port0_only", rdat[31:0], 32'h33);
        chk32("bypass_other_port_unaffected", rdat[63:32], 32'h22);
        tick();
        idle();
    endtask

    task automatic test_scoreboard();
        idle(); claim_en = 1'b1; claim_sel = 5'd9; set_rd(5'd9, 5'd0);
        #1;
        n_cmp++;
        if (rbusy[0] !== 1'b0) begin n_err++; $display("FAIL claim_same_cycle_rbusy: got %b expected 0", rbusy[0]); end
        tick();
        idle();
        #1;
        n_cmp++;
        if (rbusy[0] !== 1'b1) begin n_err++; $display("FAIL claim_rbusy: got %b expected 1", rbusy[0]); end
        n_cmp++;
        if (busy_vec !== 32'h0000_0200) begin n_err++; $display("FAIL claim_busy_vec: got 0x%08h expected 0x00000200", busy_vec); end
        set_wr(1, 5'd9, 32'h55);
        #1;
        n_cmp++;
        if (rbusy[0] !== 1'b0) begin n_err++; $display("FAIL write_masks_rbusy: got %b expected 0", rbusy[0]); end
        chk32("write_bypass_reg9", rdat[31:0], 32'h55);
        tick();
        idle();
        #1;
        n_cmp++;
        if (busy_vec !== 32'h0) begin n_err++; $display("FAIL write_clears_busy: got 0x%08h expected 0", busy_vec); end
        claim_en = 1'b1; claim_sel = 5'd0;
        tick();
        idle();
        n_cmp++;
        if (busy_vec !== 32'h0) begin n_err++; $display("FAIL claim_reg0_ignored: got 0x%08h expected 0", busy_vec); end
    endtask

    task automatic test_claim_and_write();
        idle(); claim_en = 1'b1; claim_sel = 5'd3; set_wr(0, 5'd3, 32'hABC);
        tick();
        idle(); set_rd(5'd3, 5'd0);
        #1;
        n_cmp++;
        if (busy_vec !== 32'h0000_0008) begin n_err++; $display("FAIL claim_wins_busy_vec: got 0x%08h expected 0x00000008", busy_vec); end
        n_cmp++;
        if (rbusy[0] !== 1'b1) begin n_err++; $display("FAIL claim_wins_rbusy: got %b expected 1", rbusy[0]); end
        chk32("claim_write_data_reg3", rdat[31:0], 32'hABC);
        set_wr(0, 5'd3, 32'h0);
        tick();
        idle();
    endtask

    task automatic test_flush();
        idle(); claim_en = 1'b1; claim_sel = 5'd2;
        tick();
        claim_sel = 5'd6;
        tick();
        idle();
        n_cmp++;
        if (busy_vec !== 32'h0000_0044) begin n_err++; $display("FAIL pre_flush_busy: got 0x%08h expected 0x00000044", busy_vec); end
        flush = 1'b1; claim_en = 1'b1; claim_sel = 5'd4; set_wr(1, 5'd2, 32'h77);
        tick();
        idle(); set_rd(5'd2, 5'd4);
        #1;
        n_cmp++;
        if (busy_vec !== 32'h0) begin n_err++; $display("FAIL flush_busy_vec: got 0x%08h expected 0", busy_vec); end
        chk32("flush_write_lands", rdat[31:0], 32'h77);
    endtask

    task automatic test_reset_mid();
        idle(); claim_en = 1'b1; claim_sel = 5'd10;
        tick();
        idle(); set_rd(5'd5, 5'd10);
        #1;
        n_cmp++;
        if (rbusy[1] !== 1'b1) begin n_err++; $display("FAIL pre_reset_rbusy: got %b expected 1", rbusy[1]); end
        chk32("pre_reset_reg5", rdat[31:0], 32'hDEADBEEF);
        #1;
        nRST = 1'b0;
        #1;
        n_cmp++;
        if (rdat !== '0) begin n_err++; $display("FAIL midreset_rdat: got 0x%016h expected 0", rdat); end
        n_cmp++;
        if (busy_vec !== '0) begin n_err++; $display("FAIL midreset_busy_vec: got 0x%08h expected 0", busy_vec); end
        n_cmp++;
        if (rbusy !== 2'b00) begin n_err++; $display("FAIL midreset_rbusy: got %b expected 00", rbusy); end
        tick();
        nRST = 1'b1;
        set_rd(5'd7, 5'd2);
        #1;
        chk32("post_reset_reg7", rdat[31:0], 32'h0);
        chk32("post_reset_reg2", rdat[63:32], 32'h0);
    endtask

    initial begin
        idle();
        rsel = '0;
        test_reset();
        test_basic_write();
        test_bypass();
        test_scoreboard();
        test_claim_and_write();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised register file for the pipelined CPU datapath, replacing the fixed 32x32, 1-write/2-read file.
- Configurable data width, register count, read-port count and write-port count.
- Adds same-cycle write-to-read forwarding and a per-register pending (scoreboard) bit, so decode can detect RAW hazards.
- Sits between decode (reads, claims) and writeback (writes).

Parameters:
- DATA_W, 32, bits per register.
- NREGS, 32, number of registers; must be a power of 2 and at least 2.
- NRD, 2, number of read ports (at least 1).
- NWR, 2, number of write ports (at least 1); higher port index has higher priority.
- SEL_W, $clog2(NREGS), register-select width; derived, not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- wen  in  NWR  per-port write enable.
- wsel  in  NWR*SEL_W  per-port write address; port k occupies bits [k*SEL_W +: SEL_W].
- wdat  in  NWR*DATA_W  per-port write data; port k occupies bits [k*DATA_W +: DATA_W].
- rsel  in  NRD*SEL_W  per-port read address.
- rdat  out  NRD*DATA_W  per-port read data (combinational).
- rbusy  out  NRD  per-port pending flag for the addressed register (combinational).
- claim_en  in  1  mark register claim_sel as pending (issue of a new producer).
- claim_sel  in  SEL_W  register being claimed.
- flush  in  1  clear all pending bits (pipeline squash).
- busy_vec  out  NREGS  registered pending bits, bit i for register i.

Behaviour:
- Reset (nRST low, async):
  - all registers are 0 and all pending bits are 0.
  - Consequently rdat is all 0, rbusy is 0 and busy_vec is 0 while reset is asserted.
- Register 0:
  - always reads 0 and is never pending.
  - Writes and claims to address 0 are ignored.
- Write, sequential:
  - on a rising edge, for each port k with wen[k]=1 and wsel[k]!=0, reg[wsel[k]] <= wdat[k].
  - Two enabled ports writing the same address in one cycle: the highest-index port's data is stored.
- Read, combinational, zero latency:
  - rdat[j] = reg[rsel[j]] by default.
  - If any enabled write port targets rsel[j] (and rsel[j]!=0) in the same cycle, rdat[j] returns that write data instead (bypass).
  - When several write ports hit the same address, the highest-index port's data is forwarded.
- Pending bits, sequential:
  - Next state per register i: if flush, 0; else if claim_en and claim_sel==i and i!=0, 1; else if any enabled write to i, 0; else hold.
  - Claim and write to the same register in the same cycle: the bit ends up 1, because the claim represents a newer producer.
  - flush with claim in the same cycle: all bits end up 0 and the claim is dropped.
  - flush does not block register writes; data writes proceed normally.
- rbusy:
  - rbusy[j] = busy_q[rsel[j]] AND NOT (an enabled write to rsel[j] this cycle).
  - The forwarded value is therefore reported as not pending.
  - A claim takes effect on rbusy from the next cycle onward.
- busy_vec: equals busy_q directly; no forwarding applied; bit 0 is always 0.
- Reset mid-operation: immediately clears all state; any in-flight write is lost.

Decomposition:
- Shared package additions to cpu_types_pkg:
  - regsel_t, a typedef of SEL_W bits for the default NREGS.
  - constant ZERO_REG = 0.
  - word_t stays the default data type when DATA_W=32.
- One sub-module, regfile_fwd_mux: combinational per-read-port priority selector over the NWR write ports.
  - Outputs: hit flag and forwarded data.
  - Instantiated NRD times; its hit flag drives both the rdat mux and rbusy masking.

Test Plan:
- Reset then read: assert nRST=0 mid-run after writes -> all rdat=0 and busy_vec=0 immediately, with no clock edge needed.
- Basic write/read: wen[0]=1, wsel=5, wdat=0xDEADBEEF; next cycle rsel[0]=5 -> rdat[0]=0xDEADBEEF. Write to reg 0 with 0x1234 -> reads still return 0.
- Bypass and priority:
  - in one cycle, port0 writes reg 7 = 0x11 and port1 writes reg 7 = 0x22, with rsel[1]=7 -> rdat[1]=0x22 in the same cycle.
  - next cycle with no write -> rdat[1]=0x22.
- Scoreboard:
  - claim reg 9 -> next cycle rbusy=1 and busy_vec[9]=1.
  - write reg 9 = 0x55 -> same cycle rbusy=0 and rdat=0x55; next cycle busy_vec[9]=0.
- Simultaneous claim and write to reg 3 -> busy_vec[3]=1 next cycle; reg3 holds the written data.
- flush with claim of reg 4 while regs 2 and 6 are pending -> busy_vec all 0 next cycle; a concurrent write of reg 2 = 0x77 still lands.
